// File: rtl/tile_map_pkg.sv
// Shared types and field layout for the tile-map renderer.
// Map entry layout is {tile, mirror[1:0], rotate[1:0]}.
package tile_map_pkg;

  localparam int ENT_ROT_LSB  = 0;
  localparam int ENT_ROT_W    = 2;
  localparam int ENT_MIR_LSB  = 2;
  localparam int ENT_MIR_W    = 2;
  localparam int ENT_TILE_LSB = ENT_MIR_LSB + ENT_MIR_W;

  localparam int MIR_X = 0;
  localparam int MIR_Y = 1;

  localparam logic [ENT_ROT_W-1:0] ROT_0   = 2'd0;
  localparam logic [ENT_ROT_W-1:0] ROT_90  = 2'd1;
  localparam logic [ENT_ROT_W-1:0] ROT_180 = 2'd2;
  localparam logic [ENT_ROT_W-1:0] ROT_270 = 2'd3;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

endpackage

// File: rtl/tile_xform.sv
// Texel coordinate transform: rotate first, then mirror.
// For N a power of two, N-1-t is the bitwise inverse of t.
module tile_xform
  import tile_map_pkg::*;
#(
  parameter int TILE_LOG2 = 2
) (
  input  logic [TILE_LOG2-1:0] i_tx,
  input  logic [TILE_LOG2-1:0] i_ty,
  input  logic [1:0]           i_mirror,
  input  logic [1:0]           i_rotate,
  output logic [TILE_LOG2-1:0] o_sx,
  output logic [TILE_LOG2-1:0] o_sy
);

  logic [TILE_LOG2-1:0] rx;
  logic [TILE_LOG2-1:0] ry;

  always_comb begin
    rx = i_tx;
    ry = i_ty;
    unique case (i_rotate)
      ROT_0: begin
        rx = i_tx;
        ry = i_ty;
      end
      ROT_90: begin
        rx = i_ty;
        ry = ~i_tx;
      end
      ROT_180: begin
        rx = ~i_tx;
        ry = ~i_ty;
      end
      ROT_270: begin
        rx = ~i_ty;
        ry = i_tx;
      end
      default: ;
    endcase
    o_sx = i_mirror[MIR_X] ? ~rx : rx;
    o_sy = i_mirror[MIR_Y] ? ~ry : ry;
  end

endmodule

// File: rtl/tile_map_engine.sv
// Per-pixel tile-map renderer: map RAM, texel transform, ROM fetch.
// Optional TILE_MAP_SCROLL_EN adds wrapping per-frame scroll offsets.
module tile_map_engine
  import tile_map_pkg::*;
#(
  parameter int          COORD_W      = 9,
  parameter int          TEXEL_LOG2   = 2,
  parameter int          TILE_LOG2    = 2,
  parameter int          MAP_COLS     = 30,
  parameter int          MAP_ROWS     = 17,
  parameter int          TILE_IDX_W   = 4,
  parameter int          ROM_ADDR_W   = 9,
  parameter int          ROM_LAT      = 1,
  parameter int          DEFAULT_TILE = 12,
  parameter logic [23:0] BG_COLOR     = 24'h000000,
  localparam int         CELLS        = MAP_COLS * MAP_ROWS,
  localparam int         AW           = $clog2(CELLS),
  localparam int         EW           = TILE_IDX_W + 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [COORD_W-1:0]    i_x,
  input  logic [COORD_W-1:0]    i_y,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [EW-1:0]         i_wr_data,
`ifdef TILE_MAP_SCROLL_EN
  input  logic                  i_frame_start,
  input  logic [COORD_W-1:0]    i_scroll_x,
  input  logic [COORD_W-1:0]    i_scroll_y,
`endif
  output logic                  o_rom_read,
  output logic [ROM_ADDR_W-1:0] o_rom_address,
  input  logic                  i_rom_valid,
  input  logic [23:0]           i_rom_data,
  output logic                  o_valid,
  output logic [23:0]           o_rgb,
  output logic                  o_busy,
  output logic                  o_rom_miss
);

  localparam int SH = TEXEL_LOG2 + TILE_LOG2;
  localparam int XW = COORD_W + 1;
  localparam int TL = TILE_LOG2;

  localparam logic [XW-1:0] COLS_X = XW'(MAP_COLS);
  localparam logic [XW-1:0] ROWS_X = XW'(MAP_ROWS);
  localparam logic [AW-1:0] COLS_A = AW'(MAP_COLS);
  localparam logic [AW-1:0] LAST_A = AW'(CELLS - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_cnt_q, clr_cnt_d;

  logic [EW-1:0]     mem_q [CELLS];
  logic              mem_we;
  logic [AW-1:0]     mem_wa;
  logic [EW-1:0]     mem_wd;

  logic [XW-1:0]     ex, ey, col, row;
  logic              off;
  logic [AW-1:0]     rd_addr;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_bg_q, s1_bg_d;
  logic [TL-1:0]     s1_tx_q, s1_tx_d;
  logic [TL-1:0]     s1_ty_q, s1_ty_d;
  logic [EW-1:0]     ent_q, ent_d;

  logic [TL-1:0]     sx, sy;
  logic [TILE_IDX_W-1:0] ent_tile;
  logic [1:0]        ent_mir, ent_rot;

  logic [ROM_LAT-1:0] dly_v_q, dly_v_d;
  logic [ROM_LAT-1:0] dly_rd_q, dly_rd_d;
  logic              head_v, head_rd;

  logic              valid_q, valid_d;
  logic [23:0]       rgb_q, rgb_d;
  logic              miss_q, miss_d;

`ifdef TILE_MAP_SCROLL_EN
  logic [COORD_W-1:0] scroll_x_q, scroll_x_d;
  logic [COORD_W-1:0] scroll_y_q, scroll_y_d;

  always_comb begin
    scroll_x_d = scroll_x_q;
    scroll_y_d = scroll_y_q;
    if (i_frame_start) begin
      scroll_x_d = i_scroll_x;
      scroll_y_d = i_scroll_y;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scroll_x_q <= '0;
      scroll_y_q <= '0;
    end else begin
      scroll_x_q <= scroll_x_d;
      scroll_y_q <= scroll_y_d;
    end
  end
`endif

  // Clear sequencer and map write port arbitration.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_wa    = i_wr_addr;
    mem_wd    = i_wr_data;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = clr_cnt_q;
        mem_wd = {TILE_IDX_W'(DEFAULT_TILE), 4'b0000};
        if (clr_cnt_q == LAST_A) begin
          state_d = RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      RUN: begin
        mem_we = i_wr_en && (i_wr_addr <= LAST_A);
      end
      default: ;
    endcase
  end

  // S0: cell lookup from pixel coordinates.
  always_comb begin
`ifdef TILE_MAP_SCROLL_EN
    ex  = {1'b0, i_x} + {1'b0, scroll_x_q};
    ey  = {1'b0, i_y} + {1'b0, scroll_y_q};
    col = ex >> SH;
    row = ey >> SH;
    if (col >= COLS_X) col = col - COLS_X;
    if (row >= ROWS_X) row = row - ROWS_X;
    off = 1'b0;
`else
    ex  = {1'b0, i_x};
    ey  = {1'b0, i_y};
    col = ex >> SH;
    row = ey >> SH;
    off = (col >= COLS_X) || (row >= ROWS_X);
`endif
    rd_addr = off ? '0 : AW'(row) * COLS_A + AW'(col);
  end

  always_comb begin
    s1_valid_d = i_valid;
    s1_bg_d    = off || (state_q == CLEAR);
    s1_tx_d    = TL'(ex >> TEXEL_LOG2);
    s1_ty_d    = TL'(ey >> TEXEL_LOG2);
    ent_d      = mem_q[rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // S1: transform and ROM request.
  assign ent_tile = ent_q[ENT_TILE_LSB +: TILE_IDX_W];
  assign ent_mir  = ent_q[ENT_MIR_LSB +: ENT_MIR_W];
  assign ent_rot  = ent_q[ENT_ROT_LSB +: ENT_ROT_W];

  tile_xform #(
    .TILE_LOG2(TILE_LOG2)
  ) u_xform (
    .i_tx    (s1_tx_q),
    .i_ty    (s1_ty_q),
    .i_mirror(ent_mir),
    .i_rotate(ent_rot),
    .o_sx    (sx),
    .o_sy    (sy)
  );

  assign o_rom_read    = s1_valid_q && !s1_bg_q;
  assign o_rom_address = ROM_ADDR_W'({ent_tile, sy, sx});

  // Track each pixel across the ROM latency.
  always_comb begin
    dly_v_d  = (dly_v_q << 1) | ROM_LAT'(s1_valid_q);
    dly_rd_d = (dly_rd_q << 1) | ROM_LAT'(o_rom_read);
  end

  assign head_v  = dly_v_q[ROM_LAT-1];
  assign head_rd = dly_rd_q[ROM_LAT-1];

  always_comb begin
    valid_d = head_v;
    rgb_d   = rgb_q;
    miss_d  = miss_q;
    if (head_v) begin
      rgb_d = (head_rd && i_rom_valid) ? i_rom_data : BG_COLOR;
      if (head_rd && !i_rom_valid) miss_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_bg_q    <= 1'b0;
      s1_tx_q    <= '0;
      s1_ty_q    <= '0;
      ent_q      <= '0;
      dly_v_q    <= '0;
      dly_rd_q   <= '0;
      valid_q    <= 1'b0;
      rgb_q      <= '0;
      miss_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_bg_q    <= s1_bg_d;
      s1_tx_q    <= s1_tx_d;
      s1_ty_q    <= s1_ty_d;
      ent_q      <= ent_d;
      dly_v_q    <= dly_v_d;
      dly_rd_q   <= dly_rd_d;
      valid_q    <= valid_d;
      rgb_q      <= rgb_d;
      miss_q     <= miss_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_rgb      = rgb_q;
  assign o_busy     = (state_q == CLEAR);
  assign o_rom_miss = miss_q;

endmodule

// File: tb/tb_tile_map_engine.sv
// Self-checking bench for tile_map_engine with a behavioural map/ROM model.
// Scroll checks are compiled in when TILE_MAP_SCROLL_EN is defined.
module tb_tile_map_engine;

  localparam int COLS  = 30;
  localparam int ROWS  = 17;
  localparam int CELLS = COLS * ROWS;
  localparam int NB    = 300;
  localparam logic [23:0] BG = 24'h1A2B3C;
`ifdef TILE_MAP_SCROLL_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic [8:0]  x_in = '0;
  logic [8:0]  y_in = '0;
  logic        wr_en = 1'b0;
  logic [8:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        rom_read;
  logic [8:0]  rom_addr;
  logic        rom_valid = 1'b0;
  logic [23:0] rom_data = '0;
  logic        o_valid;
  logic [23:0] o_rgb;
  logic        busy;
  logic        miss;
`ifdef TILE_MAP_SCROLL_EN
  logic        frame_start = 1'b0;
  logic [8:0]  scroll_x = '0;
  logic [8:0]  scroll_y = '0;
`endif

  bit   rom_hold = 1'b0;
  bit   rom_spur = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mmap [CELLS];
  int   scx = 0;
  int   scy = 0;

  tile_map_engine #(
    .BG_COLOR(BG)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (vin),
    .i_x          (x_in),
    .i_y          (y_in),
    .i_wr_en      (wr_en),
    .i_wr_addr    (wr_addr),
    .i_wr_data    (wr_data),
`ifdef TILE_MAP_SCROLL_EN
    .i_frame_start(frame_start),
    .i_scroll_x   (scroll_x),
    .i_scroll_y   (scroll_y),
`endif
    .o_rom_read   (rom_read),
    .o_rom_address(rom_addr),
    .i_rom_valid  (rom_valid),
    .i_rom_data   (rom_data),
    .o_valid      (o_valid),
    .o_rgb        (o_rgb),
    .o_busy       (busy),
    .o_rom_miss   (miss)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] rom_fn(input logic [8:0] a);
    return {a[7:0] ^ 8'h5A, ~a[7:0], 7'd0, a[8]};
  endfunction

  // One-cycle-latency ROM.
  always @(posedge clk) begin
    rom_valid <= rom_spur || (rom_read && !rom_hold);
    rom_data  <= rom_fn(rom_addr);
  end

  // Reference: look up the cell, rotate the sample point by quarter turns, mirror.
  function automatic void ref_pix(input int x, input int y,
                                  output bit on, output logic [8:0] addr);
    int ex, ey, col, row, sx, sy, tmp;
    logic [7:0] e;
    ex  = x + scx;
    ey  = y + scy;
    col = ex / 16;
    row = ey / 16;
    if (SCR) begin
      col = col % COLS;
      row = row % ROWS;
    end
    on   = (col < COLS) && (row < ROWS);
    addr = '0;
    if (on) begin
      e  = mmap[row * COLS + col];
      sx = (ex / 4) % 4;
      sy = (ey / 4) % 4;
      for (int r = 0; r < int'(e[1:0]); r++) begin
        tmp = sx;
        sx  = sy;
        sy  = 3 - tmp;
      end
      if (e[2]) sx = 3 - sx;
      if (e[3]) sy = 3 - sy;
      addr = 9'(int'(e[7:4]) * 16 + sy * 4 + sx);
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst   = 1'b1;
    vin   = 1'b0;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_rd", rom_read, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_rgb", o_rgb, 0);
    chk("rst_miss", miss, 0);
    foreach (mmap[i]) mmap[i] = 8'hC0;
    scx = 0;
    scy = 0;
  endtask

  task automatic wait_clear(input int expc);
    int cnt;
    cnt = 0;
    rst = 1'b0;
    while (busy && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    chk("clear_cycles", cnt, expc);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 9'(a);
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
    mmap[a] = d;
  endtask

  task automatic send_check(input int x, input int y, input string tag);
    bit on;
    logic [8:0] a;
    ref_pix(x, y, on, a);
    @(negedge clk);
    vin  = 1'b1;
    x_in = 9'(x);
    y_in = 9'(y);
    @(negedge clk);
    vin = 1'b0;
    chk({tag, "_rd"}, rom_read, on);
    if (on) chk({tag, "_addr"}, rom_addr, a);
    @(negedge clk);
    chk({tag, "_v2"}, o_valid, 0);
    @(negedge clk);
    chk({tag, "_v3"}, o_valid, 1);
    chk({tag, "_rgb"}, o_rgb, (on && !rom_hold) ? rom_fn(a) : BG);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ev [NB];
    bit eon [NB];
    logic [8:0] ea [NB];
    bit on_old;
    logic [8:0] a_old;
    int x, y, wa;
    logic [7:0] wd;

    reset_dut();
    wait_clear(510);

    send_check(20, 20, "default");
    wr(0, 8'h60);
    send_check(0, 0, "cell0");
    wr(1, {4'd5, 2'b00, 2'b01});
    send_check(20, 0, "rot90");
    wr(1, {4'd5, 2'b01, 2'b01});
    send_check(20, 0, "rot90_mx");
    wr(2, {4'd9, 2'b10, 2'b10});
    send_check(44, 4, "rot180_my");
    wr(3, {4'd3, 2'b11, 2'b11});
    send_check(52, 8, "rot270_mxy");

    // Back-to-back random pixels with interleaved map writes.
    for (int k = 0; k < NB + 3; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk("b_rd", rom_read, ev[k-1] && eon[k-1]);
        if (ev[k-1] && eon[k-1]) chk("b_addr", rom_addr, ea[k-1]);
      end
      if (k >= 3) begin
        chk("b_valid", o_valid, ev[k-3]);
        if (ev[k-3]) chk("b_rgb", o_rgb, eon[k-3] ? rom_fn(ea[k-3]) : BG);
      end
      vin   = 1'b0;
      wr_en = 1'b0;
      if (k < NB) begin
        ev[k] = ($urandom_range(3) != 0);
        x = $urandom_range(511);
        y = $urandom_range(300);
        ref_pix(x, y, eon[k], ea[k]);
        vin  = ev[k];
        x_in = 9'(x);
        y_in = 9'(y);
        if ($urandom_range(3) == 0) begin
          wa = $urandom_range(CELLS - 1);
          wd = 8'($urandom);
          wr_en    = 1'b1;
          wr_addr  = 9'(wa);
          wr_data  = wd;
          mmap[wa] = wd;
        end
      end
    end
    chk("miss_clean", miss, 0);

    rom_spur = 1'b1;
    send_check(480, 0, "off_x");
    send_check(0, 272, "off_y");
    rom_spur = 1'b0;

    rom_hold = 1'b1;
    send_check(20, 20, "hold");
    rom_hold = 1'b0;
    chk("miss_set", miss, 1);
    send_check(40, 40, "after_hold");
    chk("miss_sticky", miss, 1);

    // Write and read the same cell on the same edge.
    wr(5, 8'hC0);
    ref_pix(84, 0, on_old, a_old);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 9'd5;
    wr_data = 8'h7E;
    vin     = 1'b1;
    x_in    = 9'd84;
    y_in    = 9'd0;
    mmap[5] = 8'h7E;
    @(negedge clk);
    wr_en = 1'b0;
    vin   = 1'b0;
    chk("same_rd", rom_read, on_old);
    chk("same_addr", rom_addr, a_old);
    repeat (2) @(negedge clk);
    chk("same_rgb", o_rgb, rom_fn(a_old));
    send_check(84, 0, "same_new");

    // Pixels during clear, then reset in the middle of clearing.
    reset_dut();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    vin  = 1'b1;
    x_in = 9'd20;
    y_in = 9'd20;
    @(negedge clk);
    vin = 1'b0;
    chk("clr_rd", rom_read, 0);
    repeat (2) @(negedge clk);
    chk("clr_valid", o_valid, 1);
    chk("clr_rgb", o_rgb, BG);
    chk("clr_busy", busy, 1);
    reset_dut();
    wait_clear(510);
    send_check(100, 200, "post_clear");

`ifdef TILE_MAP_SCROLL_EN
    @(negedge clk);
    frame_start = 1'b1;
    scroll_x    = 9'd16;
    scroll_y    = 9'd0;
    @(negedge clk);
    frame_start = 1'b0;
    scroll_x    = 9'd0;
    scx = 16;
    wr(0, 8'h35);
    send_check(464, 0, "scroll_wrap");
    send_check(100, 8, "scroll_mid");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
